// File: rtl/five_bit_result_accumulator_if.sv
// Handshake bundle between the 5-bit add/subtract stage, the batch accumulator
// and the batch consumer. The master side drives results in and takes batches out.
interface five_bit_result_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_sum;
    logic             in_op;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;

    modport master (
        output in_valid, in_sum, in_op, out_ready,
        input  in_ready, out_valid, out_acc, out_sat
    );

    modport slave (
        input  in_valid, in_sum, in_op, out_ready,
        output in_ready, out_valid, out_acc, out_sat
    );
endinterface

// File: rtl/five_bit_result_accumulator.sv
// Sums N_SAMPLES results of a 5-bit add/subtract stage into a saturating signed
// accumulator and holds the batch total until the consumer takes it.
module five_bit_result_accumulator #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    five_bit_result_accumulator_if.slave    bus
);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [ACC_W:0]     value;
    logic [ACC_W:0]     sum;
    logic               ovf;
    logic               accept;
    logic               last;

    // IDLE guarantees acc_q and cnt_q are zero, so the first accept of a batch
    // takes the same add path as every later one.
    always_comb begin
        value  = bus.in_op ? {{(ACC_W-4){bus.in_sum[4]}}, bus.in_sum}
                           : {{(ACC_W-4){1'b0}}, bus.in_sum};
        sum    = {acc_q[ACC_W-1], acc_q} + value;
        ovf    = sum[ACC_W] ^ sum[ACC_W-1];
        acc_d  = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
        sat_d  = sat_q | ovf;
        cnt_d  = cnt_q + CNT_W'(1);
        last   = (cnt_d == CNT_W'(N_SAMPLES));
        accept = bus.in_valid & in_ready_q;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        sat_q <= sat_d;
                        if (last) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        sat_q       <= 1'b0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                    sat_q       <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = acc_q;
    assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_five_bit_result_accumulator.sv
// Directed bench: a default 8-sample instance plus a 2-sample instance, with
// expected batch totals queued at stimulus time and compared on completion.
module tb_five_bit_result_accumulator;
    logic clk;
    logic rst_n;
    logic clr;

    int compared;
    int mismatched;

    typedef struct {
        logic [7:0] acc;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   m_acc;
    logic m_sat;

    five_bit_result_accumulator_if #(.ACC_W(8)) bus8 ();
    five_bit_result_accumulator_if #(.ACC_W(8)) bus2 ();

    five_bit_result_accumulator #(.ACC_W(8), .N_SAMPLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus8)
    );

    five_bit_result_accumulator #(.ACC_W(8), .N_SAMPLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_batch();
        m_acc = 0;
        m_sat = 1'b0;
    endtask

    // Drives one accepted sample into the 8-sample instance and updates the model.
    task automatic drive_one(input logic op, input logic [4:0] s, input bit gap);
        int v;
        if (gap) begin
            @(negedge clk);
            bus8.in_valid = 1'b0;
            bus8.in_sum   = 5'($urandom);
            bus8.in_op    = 1'($urandom);
        end
        @(negedge clk);
        check("valid_early", {31'd0, bus8.out_valid}, 32'd0);
        bus8.in_valid = 1'b1;
        bus8.in_op    = op;
        bus8.in_sum   = s;
        v = (op && s[4]) ? int'(s) - 32 : int'(s);
        m_acc = m_acc + v;
        if (m_acc > 127) begin
            m_acc = 127;
            m_sat = 1'b1;
        end else if (m_acc < -128) begin
            m_acc = -128;
            m_sat = 1'b1;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.acc = 8'(m_acc);
        e.sat = m_sat;
        sb.push_back(e);
    endtask

    // One negedge after the last drive the batch must already be presented.
    task automatic finish_batch(input string tag);
        exp_t e;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check({tag, "_latency"}, {31'd0, bus8.out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_acc"}, {24'd0, bus8.out_acc}, {24'd0, e.acc});
            check({tag, "_sat"}, {31'd0, bus8.out_sat}, {31'd0, e.sat});
        end
    endtask

    task automatic release_batch(input string tag);
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        check({tag, "_rel_valid"}, {31'd0, bus8.out_valid}, 32'd0);
        check({tag, "_rel_acc"},   {24'd0, bus8.out_acc},   32'd0);
        check({tag, "_rel_ready"}, {31'd0, bus8.in_ready},  32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        bus8.in_valid = 1'b0; bus8.in_sum = '0; bus8.in_op = 1'b0; bus8.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_sum = '0; bus2.in_op = 1'b0; bus2.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready",  {31'd0, bus8.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("rst_out_acc",   {24'd0, bus8.out_acc},   32'd0);
        check("rst_out_sat",   {31'd0, bus8.out_sat},   32'd0);

        // Basic add batch: 8 x 3 = 24
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'b0, 5'd3, 1'b0);
        push_expected();
        finish_batch("add3");

        // Backpressure in DONE with in_valid held high
        bus8.in_valid = 1'b1;
        bus8.in_sum   = 5'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  {31'd0, bus8.in_ready},  32'd0);
            check("bp_out_valid", {31'd0, bus8.out_valid}, 32'd1);
            check("bp_out_acc",   {24'd0, bus8.out_acc},   32'd24);
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 1'b0;
        check("bp_idle_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("bp_idle_acc",   {24'd0, bus8.out_acc},   32'd0);
        check("bp_idle_ready", {31'd0, bus8.in_ready},  32'd1);

        // Positive saturation: 8 x 31 clamps to 127
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'b0, 5'd31, 1'b0);
        push_expected();
        finish_batch("satpos");
        release_batch("satpos");

        // Exactly the negative limit: 8 x -16 = -128, no clamp
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'b1, 5'b10000, 1'b0);
        push_expected();
        finish_batch("negmin");
        release_batch("negmin");

        // Clamp then recover: sat stays sticky while the total comes back down
        start_batch();
        for (int i = 0; i < 5; i++) drive_one(1'b0, 5'd31, i[0]);
        for (int i = 0; i < 3; i++) drive_one(1'b1, 5'b10000, 1'b1);
        push_expected();
        finish_batch("sticky");
        release_batch("sticky");

        // Random mixed values with gaps in in_valid
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'($urandom), 5'($urandom), 1'($urandom));
        push_expected();
        finish_batch("random");
        release_batch("random");

        // clr mid-batch with a simultaneous valid input
        start_batch();
        for (int i = 0; i < 3; i++) drive_one(1'b0, 5'd10, 1'b0);
        for (int i = 0; i < 2; i++) drive_one(1'b0, 5'd31, 1'b0);
        @(negedge clk);
        bus8.in_valid = 1'b1;
        bus8.in_sum   = 5'd31;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        bus8.in_valid = 1'b0;
        check("clr_acc",   {24'd0, bus8.out_acc},   32'd0);
        check("clr_sat",   {31'd0, bus8.out_sat},   32'd0);
        check("clr_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("clr_ready", {31'd0, bus8.in_ready},  32'd1);

        // A full batch after clr proves the count restarted from zero
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'b0, 5'd1, 1'b0);
        push_expected();
        finish_batch("postclr");
        release_batch("postclr");

        // Reset while a saturated result waits in DONE
        start_batch();
        for (int i = 0; i < 8; i++) drive_one(1'b0, 5'd31, 1'b0);
        push_expected();
        finish_batch("prerst");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstdone_valid", {31'd0, bus8.out_valid}, 32'd0);
        check("rstdone_acc",   {24'd0, bus8.out_acc},   32'd0);
        check("rstdone_sat",   {31'd0, bus8.out_sat},   32'd0);
        check("rstdone_ready", {31'd0, bus8.in_ready},  32'd1);

        // Mixed signs on the 2-sample instance: -2 + 7 = 5
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_op    = 1'b1;
        bus2.in_sum   = 5'b11110;
        @(negedge clk);
        check("n2_valid_early", {31'd0, bus2.out_valid}, 32'd0);
        bus2.in_op  = 1'b0;
        bus2.in_sum = 5'd7;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        check("n2_valid", {31'd0, bus2.out_valid}, 32'd1);
        check("n2_acc",   {24'd0, bus2.out_acc},   32'd5);
        check("n2_sat",   {31'd0, bus2.out_sat},   32'd0);
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        check("n2_rel_valid", {31'd0, bus2.out_valid}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/five_bit_result_accumulator.md
FIVE_BIT_RESULT_ACCUMULATOR -- requirements
Module: five_bit_result_accumulator

Interface
REQ-001 Parameter ACC_W, default 8: accumulator width in bits, two's complement signed; legal range 6..16.
REQ-002 Parameter N_SAMPLES, default 8: number of results accumulated per batch; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port clr, input, 1: synchronous batch abort.
REQ-006 Port in_valid, input, 1: in_sum/in_op valid this cycle.
REQ-007 Port in_ready, output, 1: block can accept a result this cycle.
REQ-008 Port in_sum, input, 5: result word from the 5-bit add/subtract stage.
REQ-009 Port in_op, input, 1: operation that produced in_sum; 0 = add, 1 = subtract.
REQ-010 Port out_valid, output, 1: batch result available.
REQ-011 Port out_ready, input, 1: consumer takes the batch result.
REQ-012 Port out_acc, output, ACC_W: signed batch total.
REQ-013 Port out_sat, output, 1: batch total clamped at least once.

Function
REQ-014 The block SHALL accept one input on every cycle where in_valid and in_ready are both 1.
REQ-015 The block SHALL convert an accepted input to a signed value as follows: in_op=0 gives zero-extension (0..31); in_op=1 gives sign-extension of bit 4 (-16..15).
REQ-016 The FSM SHALL have three states:
- IDLE: in_ready=1, out_valid=0, accumulator=0, count=0.
- ACCUM: in_ready=1, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-017 In IDLE, an accept SHALL load acc=value and count=1. The next state SHALL be DONE if N_SAMPLES=1, else ACCUM.
REQ-018 In ACCUM, an accept SHALL set acc=acc+value and count=count+1. On the accept that makes count equal N_SAMPLES, the next state SHALL be DONE.
REQ-019 Additions SHALL be computed at ACC_W+1 bits. A result above 2^(ACC_W-1)-1 SHALL be clamped to that value, and a result below -2^(ACC_W-1) SHALL be clamped to that value. Any clamp SHALL set the sticky sat bit.
REQ-020 out_acc SHALL present the accumulator register in every state and SHALL be stable throughout DONE.
REQ-021 out_sat SHALL present the sticky sat bit. It SHALL be cleared only on return to IDLE, on clr, or on reset.
REQ-022 out_valid SHALL rise on the cycle after the N_SAMPLES-th accept (one-cycle latency).
REQ-023 In DONE, with out_ready=1, the block SHALL go to IDLE on the next edge. With out_ready=0, it SHALL hold all outputs indefinitely.
REQ-024 In DONE, in_valid SHALL be ignored and no input SHALL be consumed.
REQ-025 clr=1 SHALL force IDLE, acc=0, count=0, sat=0 on the next edge from any state. clr SHALL override a simultaneous accept or out_ready.
REQ-026 A DONE->IDLE transition SHALL NOT accept an input in the same cycle, because in_ready is 0 in DONE. The first input of the next batch SHALL be accepted no earlier than one cycle after out_ready handshakes.
REQ-027 Gaps in in_valid while in ACCUM SHALL leave acc, count and sat unchanged.

Reset
REQ-028 When rst_n=0 at a rising edge, the block SHALL enter IDLE with acc=0, count=0, sat=0. The outputs SHALL then be in_ready=1, out_valid=0, out_acc=0, out_sat=0.
REQ-029 rst_n SHALL take priority over clr and all handshakes. A reset asserted mid-batch or in DONE SHALL discard the partial or pending result.
REQ-030 The block SHALL have no asynchronous reset path. Outputs are undefined before the first rst_n=0 edge.

Verification
REQ-031 Basic add batch (defaults): 8 accepts of in_op=0, in_sum=5'd3 -> out_valid=1 one cycle after the 8th accept, out_acc=24, out_sat=0.
REQ-032 Mixed signs (N_SAMPLES=2): accept in_op=1, in_sum=5'b11110 (-2), then in_op=0, in_sum=5'd7 -> out_acc=5, out_sat=0.
REQ-033 Saturation (ACC_W=8): 8 accepts of in_op=0, in_sum=5'd31 (sum 248) -> out_acc=127, out_sat=1. Same with in_op=1, in_sum=5'b10000 (-16) ×8 (sum -128) -> out_acc=-128, out_sat=0.
REQ-034 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 -> in_ready=0, out_acc unchanged, no input consumed. Then out_ready=1 -> IDLE next cycle, out_acc=0.
REQ-035 clr and reset mid-batch: after 3 accepts, assert clr with in_valid=1 -> IDLE, acc=0, input not counted. Repeat with rst_n=0 in DONE -> out_valid=0 next edge, out_acc=0, out_sat=0.
